// File: rtl/serial_out_if.sv
// CPU-side bus of the serial transmitter: write strobe, write data,
// status word and the serial line itself.
interface serial_out_if;
   logic        load;
   logic [15:0] in;
   logic [15:0] out;
   logic        tx;

   modport master (output load, output in, input out, input tx);
   modport slave  (input load, input in, output out, output tx);
endinterface

// File: rtl/serial_out.sv
// Memory-mapped 8N1 serial transmitter with a small byte FIFO.
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (low) for CLKS_PER_BIT cycles
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high); chains straight into START if more bytes wait
module serial_out #(
   parameter int CLKS_PER_BIT = 104,
   parameter int DEPTH        = 4
) (
   input logic        clk,
   input logic        rst_n,
   serial_out_if.slave bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state, state_nx;
   logic [BW-1:0]   baud, baud_nx;
   logic [2:0]      bit_idx, bit_idx_nx;
   logic [7:0]      shift, shift_nx;
   logic            tx_q, tx_nx;

   logic [7:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count;
   logic            overflow;

   logic data_wr, ctrl_wr, push, pop, full, empty, baud_end, busy;
   logic unused_in;

   assign data_wr  = bus.load & ~bus.in[15];
   assign ctrl_wr  = bus.load & bus.in[15];
   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   // Acceptance looks only at the pre-edge count, so a same-edge pop never
   // makes room for a write that arrives at a full FIFO.
   assign push     = data_wr & ~full;
   assign baud_end = (baud == BW'(CLKS_PER_BIT - 1));
   assign busy     = (state != IDLE) | ~empty;
   assign unused_in = ^bus.in[14:8];

   assign bus.out = {busy, full, overflow, 9'b0, 4'(count)};
   assign bus.tx  = tx_q;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   // Next-state, bit sequencing and FIFO pop decision.
   always_comb begin
      state_nx   = state;
      baud_nx    = baud;
      bit_idx_nx = bit_idx;
      shift_nx   = shift;
      pop        = 1'b0;
      case (state)
         IDLE: begin
            baud_nx = '0;
            if (!empty) begin
               pop        = 1'b1;
               shift_nx   = mem[rd_ptr];
               bit_idx_nx = '0;
               state_nx   = START;
            end
         end
         START: begin
            if (baud_end) begin
               baud_nx  = '0;
               state_nx = DATA;
            end else begin
               baud_nx = baud + BW'(1);
            end
         end
         DATA: begin
            if (baud_end) begin
               baud_nx = '0;
               if (bit_idx == 3'd7) begin
                  state_nx = STOP;
               end else begin
                  bit_idx_nx = bit_idx + 3'd1;
                  shift_nx   = {1'b0, shift[7:1]};
               end
            end else begin
               baud_nx = baud + BW'(1);
            end
         end
         STOP: begin
            if (baud_end) begin
               baud_nx = '0;
               if (!empty) begin
                  pop        = 1'b1;
                  shift_nx   = mem[rd_ptr];
                  bit_idx_nx = '0;
                  state_nx   = START;
               end else begin
                  state_nx = IDLE;
               end
            end else begin
               baud_nx = baud + BW'(1);
            end
         end
         default: state_nx = IDLE;
      endcase

      // Line level is derived from the state being entered so tx is a clean flop.
      case (state_nx)
         START:   tx_nx = 1'b0;
         DATA:    tx_nx = shift_nx[0];
         default: tx_nx = 1'b1;
      endcase
   end

   // Transmit FSM registers; reset abandons any partial frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         baud    <= '0;
         bit_idx <= '0;
         shift   <= '0;
         tx_q    <= 1'b1;
      end else begin
         state   <= state_nx;
         baud    <= baud_nx;
         bit_idx <= bit_idx_nx;
         shift   <= shift_nx;
         tx_q    <= tx_nx;
      end
   end

   // FIFO pointers, occupancy and sticky overflow flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (ctrl_wr)
            overflow <= 1'b0;
         else if (data_wr && full)
            overflow <= 1'b1;
      end
   end

   // FIFO storage needs no reset; only slots behind the pointers are read.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.in[7:0];
   end
endmodule

// File: tb/tb_serial_out.sv
// Directed bench for serial_out at CLKS_PER_BIT=4, DEPTH=4.
module tb_serial_out;
   logic clk = 1'b0;
   logic rst_n = 1'b0;

   serial_out_if bus_if ();

   serial_out #(.CLKS_PER_BIT(4), .DEPTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        load;
      logic [15:0] din;
      logic [15:0] exp_out;
      logic        exp_tx;
   } vec_t;

   vec_t       vecs[$];
   logic [7:0] exp_bytes[$];
   int         n_cmp = 0;
   int         n_fail = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Apply one cycle of bus inputs, then sample just after the rising edge.
   task automatic tick(input logic l, input logic [15:0] d);
      bus_if.load = l;
      bus_if.in   = d;
      @(posedge clk);
      #1;
      bus_if.load = 1'b0;
      bus_if.in   = 16'h0;
   endtask

   // Expected line level t cycles after the first write edge, for the
   // back-to-back frames listed in exp_bytes (first frame starts at t=1).
   function automatic logic exp_tx_at(input int t);
      int p, f, s;
      logic [7:0] b;
      if (t < 1 || t > exp_bytes.size() * 40) return 1'b1;
      p = t - 1;
      f = p / 40;
      s = (p % 40) / 4;
      if (s == 0) return 1'b0;
      if (s == 9) return 1'b1;
      b = exp_bytes[f];
      return b[s-1];
   endfunction

   function automatic vec_t mk(input logic l, input logic [15:0] d,
                               input logic [15:0] o, input logic t);
      vec_t v;
      v.load = l; v.din = d; v.exp_out = o; v.exp_tx = t;
      return v;
   endfunction

   initial begin
      logic [7:0]  b;
      logic [15:0] eo;
      int          slot;

      bus_if.load = 1'b0;
      bus_if.in   = 16'h0;

      // ---- single byte 0x55 table ----
      b = 8'h55;
      vecs.push_back(mk(1'b1, 16'h0055, 16'h8001, 1'b1));
      for (int c = 0; c < 40; c++) begin
         slot = c / 4;
         vecs.push_back(mk(1'b0, 16'h0, 16'h8000,
                           (slot == 0) ? 1'b0 : (slot == 9) ? 1'b1 : b[slot-1]));
      end
      vecs.push_back(mk(1'b0, 16'h0, 16'h0000, 1'b1));

      // ---- reset values ----
      repeat (3) @(posedge clk);
      #1;
      check("rst_out", bus_if.out, 16'h0000);
      check("rst_tx", {15'b0, bus_if.tx}, 16'h0001);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 50; i++) begin
         tick(1'b0, 16'h0);
         check("idle_out", bus_if.out, 16'h0000);
         check("idle_tx", {15'b0, bus_if.tx}, 16'h0001);
      end

      // ---- single byte ----
      foreach (vecs[i]) begin
         tick(vecs[i].load, vecs[i].din);
         check("single_out", bus_if.out, vecs[i].exp_out);
         check("single_tx", {15'b0, bus_if.tx}, {15'b0, vecs[i].exp_tx});
      end

      // ---- back-to-back 0x41,0x42,0x43 ----
      exp_bytes = '{8'h41, 8'h42, 8'h43};
      for (int t = 0; t <= 121; t++) begin
         if (t <= 2) tick(1'b1, 16'h0041 + 16'(t));
         else        tick(1'b0, 16'h0);
         if (t <= 1)       eo = 16'h8001;
         else if (t <= 40) eo = 16'h8002;
         else if (t <= 80) eo = 16'h8001;
         else if (t <= 120) eo = 16'h8000;
         else              eo = 16'h0000;
         check("b2b_out", bus_if.out, eo);
         check("b2b_tx", {15'b0, bus_if.tx}, {15'b0, exp_tx_at(t)});
      end

      // ---- overflow: six writes, five survive ----
      exp_bytes = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
      for (int t = 0; t <= 201; t++) begin
         if (t <= 5)      tick(1'b1, 16'h0010 + 16'(t));
         else if (t == 6) tick(1'b1, 16'h8000);
         else             tick(1'b0, 16'h0);
         check("ovf_tx", {15'b0, bus_if.tx}, {15'b0, exp_tx_at(t)});
         if (t == 4)   check("ovf_full", bus_if.out, 16'hC004);
         if (t == 5)   check("ovf_set", bus_if.out, 16'hE004);
         if (t == 6)   check("ovf_clear", bus_if.out, 16'hC004);
         if (t == 41)  check("ovf_cnt3", bus_if.out, 16'h8003);
         if (t == 200) check("ovf_last", bus_if.out, 16'h8000);
         if (t == 201) check("ovf_done", bus_if.out, 16'h0000);
      end

      // ---- write at full on the STOP->START pop edge ----
      exp_bytes = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24};
      for (int t = 0; t <= 201; t++) begin
         if (t <= 4)       tick(1'b1, 16'h0020 + 16'(t));
         else if (t == 41) tick(1'b1, 16'h0099);
         else              tick(1'b0, 16'h0);
         check("fp_tx", {15'b0, bus_if.tx}, {15'b0, exp_tx_at(t)});
         if (t == 40)  check("fp_before", bus_if.out, 16'hC004);
         if (t == 41)  check("fp_reject", bus_if.out, 16'hA003);
         if (t == 201) check("fp_sticky", bus_if.out, 16'h2000);
      end
      tick(1'b1, 16'h8000);
      check("fp_cleared", bus_if.out, 16'h0000);

      // ---- reset during DATA bit 3 ----
      exp_bytes = '{8'hF0, 8'h11};
      for (int t = 0; t <= 18; t++) begin
         if (t <= 1) tick(1'b1, (t == 0) ? 16'h00F0 : 16'h0011);
         else        tick(1'b0, 16'h0);
         check("mid_tx", {15'b0, bus_if.tx}, {15'b0, exp_tx_at(t)});
      end
      check("mid_pre_out", bus_if.out, 16'h8001);
      rst_n = 1'b0;
      #1;
      check("mid_rst_tx", {15'b0, bus_if.tx}, 16'h0001);
      check("mid_rst_out", bus_if.out, 16'h0000);
      repeat (2) @(posedge clk);
      #1;
      check("mid_hold_out", bus_if.out, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick(1'b0, 16'h0);
         check("post_rst_tx", {15'b0, bus_if.tx}, 16'h0001);
         check("post_rst_out", bus_if.out, 16'h0000);
      end
      exp_bytes = '{8'hA5};
      for (int t = 0; t <= 41; t++) begin
         if (t == 0) tick(1'b1, 16'h00A5);
         else        tick(1'b0, 16'h0);
         check("a5_tx", {15'b0, bus_if.tx}, {15'b0, exp_tx_at(t)});
      end
      check("a5_done", bus_if.out, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
